intctl_seq: RTL
===============

# intctl_seq

Sequential 4-source interrupt controller that wraps the priority-encode/mux selection path in a stateful request/acknowledge/end-of-interrupt handshake. Rising edges on int_a..int_d are latched as pending and filtered by a writable mask. One eligible source is selected by priority, fixed or round-robin. The controller drives a single irq line and a vector to the CPU, and holds that source in service until end-of-interrupt. Mode input m keeps the direct-source-A behaviour of the combinational selector: when m=0 only int_a is serviced.

## Interface
Parameters:
- ROTATE, default 0: 0 = fixed priority (d > c > b > a); 1 = round-robin starting after the last serviced source.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m  in  1  mode: 0 = only source a is eligible; 1 = all four sources are eligible.
- int_a, int_b, int_c, int_d  in  1 each  interrupt request lines; synchronous to clock; rising-edge sensitive.
- mask_we  in  1  write strobe for the mask register.
- mask_in  in  4  new mask value; bit0 = a … bit3 = d; 1 = masked.
- ack  in  1  CPU acknowledges the current irq/vec.
- eoi  in  1  CPU end-of-interrupt for the source in service.
- irq  out  1  interrupt request to the CPU; high only in state REQ.
- vec  out  2  index of the requested or serviced source (0 = a … 3 = d).
- busy  out  1  high only in state SERVICE.
- pending  out  4  latched pending bits.
- mask  out  4  current mask register.

## Operation
- Reset values: pending=0, mask=0, prev (previous sample of the int lines)=0, state=IDLE, vec=0, last=3, irq=0, busy=0.
- Edge detection: the rising edge on source i is `int_i & ~prev[i]`. prev is updated every clock. An input that is high on the first clock after reset release counts as an edge.
- Pending update each clock:
  - pending[i] is set on an edge of source i.
  - pending[vec] is cleared on an accepted ack.
  - If an edge and a clear hit the same bit in the same cycle, the set wins.
- Mask register: on mask_we, mask <= mask_in. Masking never clears pending bits.
- Eligibility:
  - elig = pending & ~mask.
  - If m=0, elig is restricted to bit0 only.
- Selection:
  - ROTATE=0: highest eligible index wins.
  - ROTATE=1: the first eligible index searching upward from (last+1) mod 4, wrapping.
- FSM:
  - IDLE: if elig≠0, latch the selected index into vec and go to REQ. Otherwise stay.
  - REQ: irq=1 and vec is held stable.
    - If elig[vec]=0 (masked, or m dropped to 0 for vec≠0), go to IDLE without a grant. Pending is kept.
    - Else if ack=1, clear pending[vec], set last<=vec, go to SERVICE.
  - SERVICE: busy=1, vec is held. eoi=1 → IDLE. New edges are still latched as pending.
- ack outside REQ and eoi outside SERVICE are ignored.
- A new source with higher priority does not preempt REQ or SERVICE. Selection happens only in IDLE.
- An asynchronous reset in any state returns every register to its reset value immediately. Any interrupt in progress is lost.

## Timing
- Edge sampled at clock k → pending visible after k. Controller enters REQ at k+1, so irq is high from k+1. Minimum input-to-irq latency is 2 clocks.
- ack sampled high at the clock where state=REQ: irq falls and busy rises after that edge; the pending bit is clear after the same edge.
- eoi sampled in SERVICE → IDLE after that edge. The next REQ occurs no earlier than the following clock, so IDLE lasts at least 1 cycle.
- irq, busy and vec are registered outputs with no combinational path from the inputs.

## Test plan
- Reset with int_c held high; release; keep int_c high → pending=0100 after the 1st clock, irq=1 and vec=2 after the 2nd clock; ack → busy=1, pending=0000; eoi → IDLE, irq stays 0.
- ROTATE=0, m=1, edges on a, b and d in the same cycle → vec=3 first. After ack+eoi, vec=1. Then vec=0.
- ROTATE=1, m=1, all four pending, last=3 after reset → service order 0, 1, 2, 3. Repeat edges → order restarts at 0.
- m=0, edges on b and d only → irq stays 0 for 20 cycles. Edge on a → vec=0. Set m=1 after EOI → vec=3.
- In REQ with vec=2, write mask_in=0100 → irq drops the next clock, pending[2] stays 1; unmask → irq=1, vec=2 again.
- Edge on source 1 in the same cycle as ack for vec=1 → pending[1] stays 1, and after eoi it is requested again. Drop reset_n mid-SERVICE → busy=0, pending=0 and mask=0 asynchronously.

Source files
------------

// File: rtl/intctl_seq.sv
// intctl_seq: sequential 4-source interrupt controller.
//
// Rising edges on int_a..int_d are latched as pending bits and filtered by a
// writable mask. In IDLE one eligible source is selected (fixed priority
// d > c > b > a, or round-robin after the last serviced source when
// ROTATE=1). The controller then raises irq with vec until the CPU acks,
// and holds that source in service (busy) until eoi. With m=0 only source a
// can be selected.
//
// Ports:
//   clock            in   system clock, rising-edge active
//   reset_n          in   asynchronous active-low reset
//   m                in   0: only int_a eligible, 1: all sources eligible
//   int_a..int_d     in   interrupt request lines (rising-edge sensitive)
//   mask_we          in   mask register write strobe
//   mask_in[3:0]     in   new mask value, bit i masks source i
//   ack              in   CPU acknowledge of irq/vec (used only in REQ)
//   eoi              in   CPU end-of-interrupt (used only in SERVICE)
//   irq              out  interrupt request, high only in REQ
//   vec[1:0]         out  index of the requested/serviced source
//   busy             out  high only in SERVICE
//   pending[3:0]     out  latched pending bits
//   mask[3:0]        out  current mask register
module intctl_seq #(
    parameter int ROTATE = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       m,
    input  logic       int_a,
    input  logic       int_b,
    input  logic       int_c,
    input  logic       int_d,
    input  logic       mask_we,
    input  logic [3:0] mask_in,
    input  logic       ack,
    input  logic       eoi,
    output logic       irq,
    output logic [1:0] vec,
    output logic       busy,
    output logic [3:0] pending,
    output logic [3:0] mask
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_prev;
    logic [3:0] r_pending;
    logic [3:0] r_mask;
    logic [1:0] r_vec;
    logic [1:0] r_last;
    logic       r_irq;
    logic       r_busy;

    logic [3:0] w_int;
    logic [3:0] w_edge;
    logic [3:0] w_elig;
    logic [1:0] w_sel;
    logic [1:0] w_vec_nxt;
    logic [1:0] w_last_nxt;
    logic [3:0] w_clr;

    // Fixed priority: the highest eligible index wins.
    function automatic logic [1:0] f_sel_fixed(input logic [3:0] elig);
        logic [1:0] sel;
        sel = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (elig[k]) begin
                sel = 2'(k);
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    // Round-robin: first eligible index searching upward from last+1.
    // Scanning the offsets from far to near lets the nearest one win.
    function automatic logic [1:0] f_sel_rr(input logic [3:0] elig,
                                            input logic [1:0] last);
        logic [1:0] sel;
        logic [1:0] idx;
        sel = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = last + 2'd1 + 2'(k);
            if (elig[idx]) begin
                sel = idx;
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    assign w_int  = {int_d, int_c, int_b, int_a};
    assign w_edge = w_int & ~r_prev;
    // With m=0 only source a may ever be selected or kept in REQ.
    assign w_elig = (r_pending & ~r_mask) & (m ? 4'b1111 : 4'b0001);
    assign w_sel  = (ROTATE != 0) ? f_sel_rr(w_elig, r_last) : f_sel_fixed(w_elig);

    // Next-state, vector latch, grant bookkeeping and pending-clear decode.
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_last_nxt  = r_last;
        w_clr       = 4'b0000;
        case (r_state)
            ST_IDLE: begin
                if (w_elig != 4'b0000) begin
                    w_state_nxt = ST_REQ;
                    w_vec_nxt   = w_sel;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Withdraw without a grant if the requested source lost
                // eligibility; its pending bit is left untouched.
                if (!w_elig[r_vec]) begin
                    w_state_nxt = ST_IDLE;
                end else if (ack) begin
                    w_state_nxt = ST_SERVICE;
                    w_clr       = 4'b0001 << r_vec;
                    w_last_nxt  = r_vec;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SERVICE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, vector, last-serviced and registered irq/busy outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_vec   <= 2'd0;
            r_last  <= 2'd3;
            r_irq   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_last  <= w_last_nxt;
            r_irq   <= (w_state_nxt == ST_REQ);
            r_busy  <= (w_state_nxt == ST_SERVICE);
        end
    end

    // Edge history, pending bits (a new edge beats a same-cycle clear) and mask.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prev    <= 4'b0000;
            r_pending <= 4'b0000;
            r_mask    <= 4'b0000;
        end else begin
            r_prev    <= w_int;
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (mask_we) begin
                r_mask <= mask_in;
            end else begin
                r_mask <= r_mask;
            end
        end
    end

    assign irq     = r_irq;
    assign busy    = r_busy;
    assign vec     = r_vec;
    assign pending = r_pending;
    assign mask    = r_mask;

endmodule
